// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader in front of the single-cycle cpu.
// It takes instruction words from a valid/ready stream and writes each one
// into the cpu instruction memory through the initialize / data / address
// port. The cpu is held in reset until the whole program is written and
// RST_HOLD further cycles have passed. After that the cpu runs from BASE_ADDR.
// Optional feature: define LOADER_CHECKSUM_EN to add the in_checksum input.
// The loader then verifies a 32-bit wrapping sum of the program before it
// releases the cpu.
module instr_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter int unsigned RST_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] length,
  input  logic [31:0] in_data,
  input  logic        in_valid,
`ifdef LOADER_CHECKSUM_EN
  input  logic [31:0] in_checksum,
`endif
  output logic        in_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    HOLD,
    RUN
  } state_t;

  state_t      state;
  logic [15:0] len_q;
  logic [15:0] index;
  logic [15:0] hold_cnt;

  logic        len_bad;
  logic        handshake;
  logic        start_ok;
  logic [16:0] index_next;
  logic [31:0] word_addr;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic [31:0] checksum_q;
`endif

  // A zero-length program or one larger than the memory is refused at start.
  // Because the length can never exceed DEPTH, no write ever lands at or past
  // BASE_ADDR + DEPTH*ADDR_STEP.
  assign len_bad    = (length == 16'd0) || ({16'd0, length} > DEPTH);
  assign start_ok   = start && ((state == IDLE) || (state == RUN));
  assign handshake  = (state == LOAD) && in_valid && in_ready;
  assign index_next = {1'b0, index} + 17'd1;
  assign word_addr  = BASE_ADDR + ({16'd0, index} * ADDR_STEP);

  // Loader sequencing IDLE -> LOAD -> FLUSH -> HOLD -> RUN, with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                          <= IDLE;
      len_q                          <= 16'd0;
      index                          <= 16'd0;
      hold_cnt                       <= 16'd0;
      in_ready                       <= 1'b0;
      initialize                     <= 1'b0;
      instruction_initialize_data    <= 32'd0;
      instruction_initialize_address <= BASE_ADDR;
      cpu_rst                        <= 1'b1;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      error                          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum                            <= 32'd0;
      checksum_q                     <= 32'd0;
`endif
    end else if (start_ok) begin
      // A new session puts the cpu back into reset in both cases, even when the length is refused.
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      initialize <= 1'b0;
      hold_cnt   <= 16'd0;
      if (len_bad) begin
        error    <= 1'b1;
        busy     <= 1'b0;
        in_ready <= 1'b0;
        state    <= IDLE;
      end else begin
        error    <= 1'b0;
        busy     <= 1'b1;
        in_ready <= 1'b1;
        len_q    <= length;
        index    <= 16'd0;
        state    <= LOAD;
`ifdef LOADER_CHECKSUM_EN
        sum        <= 32'd0;
        checksum_q <= in_checksum;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          cpu_rst    <= 1'b1;
          in_ready   <= 1'b0;
          initialize <= 1'b0;
        end
        LOAD: begin
          if (handshake) begin
            instruction_initialize_data    <= in_data;
            instruction_initialize_address <= word_addr;
            initialize                     <= 1'b1;
            index                          <= index_next[15:0];
`ifdef LOADER_CHECKSUM_EN
            sum                            <= sum + in_data;
`endif
            if (index_next >= {1'b0, len_q}) begin
              in_ready <= 1'b0;
              state    <= FLUSH;
            end else begin
              in_ready <= 1'b1;
            end
          end else begin
            initialize <= 1'b0;
          end
        end
        FLUSH: begin
          // The final write pulse is on the bus during this cycle.
          initialize <= 1'b0;
          hold_cnt   <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
          if (sum != checksum_q) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
`else
          state <= HOLD;
`endif
        end
        HOLD: begin
          if (hold_cnt == 16'(RST_HOLD - 1)) begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= RUN;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        RUN: begin
          cpu_rst <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed-vector bench for instr_loader (DEPTH=64, BASE_ADDR=0,
// ADDR_STEP=4, RST_HOLD=2). Every write pulse is captured into queues so the
// bench can compare addresses, data and pulse timing with hand-computed values.
// Build with LOADER_CHECKSUM_EN defined to also cover the checksum path.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] length = 16'd0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_checksum = 32'd0;
  logic        in_ready;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  instr_loader #(
    .DEPTH(64),
    .BASE_ADDR(32'h0),
    .ADDR_STEP(32'd4),
    .RST_HOLD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .length(length),
    .in_data(in_data),
    .in_valid(in_valid),
`ifdef LOADER_CHECKSUM_EN
    .in_checksum(in_checksum),
`endif
    .in_ready(in_ready),
    .initialize(initialize),
    .instruction_initialize_data(instruction_initialize_data),
    .instruction_initialize_address(instruction_initialize_address),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // Free-running clock plus a cycle counter used to timestamp write pulses.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every cycle in which the write strobe is high.
  always @(negedge clk) begin
    if (!rst && initialize) begin
      wr_addr_q.push_back(instruction_initialize_address);
      wr_data_q.push_back(instruction_initialize_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_at(input int i);
    return (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    return (i < wr_data_q.size()) ? wr_data_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < wr_cyc_q.size()) ? wr_cyc_q[i] : -100;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Pulse start for one cycle with the given length and checksum.
  task automatic applyStimulus(input logic [15:0] len, input logic [31:0] cks);
    start       = 1'b1;
    length      = len;
    in_checksum = cks;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one word, wait (bounded) for in_ready, and return after the handshake edge.
  task automatic send_word(input logic [31:0] w, input bit gap);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  initial begin
    // Test 1: reset values while rst is held high.
    @(negedge clk);
    checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("rst_initialize", 32'(initialize), 32'd0);
    checkOutput("rst_address", instruction_initialize_address, 32'h0);
    checkOutput("rst_data", instruction_initialize_data, 32'h0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 2: three words back-to-back, followed by the reset hold timing.
    clear_log();
    applyStimulus(16'd3, 32'd0);
    checkOutput("t2_busy", 32'(busy), 32'd1);
    send_word(32'h2001_0005, 1'b0);
    send_word(32'h2002_0003, 1'b0);
    send_word(32'h0022_1820, 1'b0);
    in_valid = 1'b0;
    checkOutput("t2_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("t2_hold1_cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    checkOutput("t2_hold2_cpu_rst", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    checkOutput("t2_run_cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_busy_low", 32'(busy), 32'd0);
    checkOutput("t2_pulses", 32'(wr_addr_q.size()), 32'd3);
    checkOutput("t2_addr0", addr_at(0), 32'h0);
    checkOutput("t2_addr1", addr_at(1), 32'h4);
    checkOutput("t2_addr2", addr_at(2), 32'h8);
    checkOutput("t2_data0", data_at(0), 32'h2001_0005);
    checkOutput("t2_data1", data_at(1), 32'h2002_0003);
    checkOutput("t2_data2", data_at(2), 32'h0022_1820);
    checkOutput("t2_consec01", 32'(cyc_at(1) - cyc_at(0)), 32'd1);
    checkOutput("t2_consec12", 32'(cyc_at(2) - cyc_at(1)), 32'd1);

    // Test 3: restart from RUN; in_valid is high only on every other cycle.
    clear_log();
    applyStimulus(16'd4, 32'd0);
    checkOutput("t3_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("t3_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + 32'(i), 1'b1);
    checkOutput("t3_ready_after", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_ready_held_low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_done("t3_done");
    checkOutput("t3_pulses", 32'(wr_addr_q.size()), 32'd4);
    checkOutput("t3_addr0", addr_at(0), 32'h0);
    checkOutput("t3_addr1", addr_at(1), 32'h4);
    checkOutput("t3_addr2", addr_at(2), 32'h8);
    checkOutput("t3_addr3", addr_at(3), 32'hC);
    checkOutput("t3_data3", data_at(3), 32'h1000_0003);

    // Test 4: refused lengths, then a valid start issued together with in_valid.
    clear_log();
    applyStimulus(16'd0, 32'd0);
    checkOutput("t4_len0_error", 32'(error), 32'd1);
    checkOutput("t4_len0_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("t4_len0_done", 32'(done), 32'd0);
    checkOutput("t4_len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    applyStimulus(16'd65, 32'd0);
    checkOutput("t4_len65_error", 32'(error), 32'd1);
    checkOutput("t4_len65_busy", 32'(busy), 32'd0);
    checkOutput("t4_len65_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    @(negedge clk);
    checkOutput("t4_idle_ready", 32'(in_ready), 32'd0);
    checkOutput("t4_idle_error_sticky", 32'(error), 32'd1);
    applyStimulus(16'd1, 32'd0);
    checkOutput("t4_error_cleared", 32'(error), 32'd0);
    checkOutput("t4_no_early_write", 32'(wr_addr_q.size()), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("t4_done");
    checkOutput("t4_pulses", 32'(wr_addr_q.size()), 32'd1);
    checkOutput("t4_addr", addr_at(0), 32'h0);
    checkOutput("t4_data", data_at(0), 32'h5555_AAAA);

    // Test 5: an asynchronous reset in the middle of a five-word load.
    clear_log();
    applyStimulus(16'd5, 32'd0);
    send_word(32'hAAAA_0001, 1'b0);
    send_word(32'hAAAA_0002, 1'b0);
    checkOutput("t5_pre_init", 32'(initialize), 32'd1);
    checkOutput("t5_pre_addr", instruction_initialize_address, 32'h4);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_async_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("t5_async_init", 32'(initialize), 32'd0);
    checkOutput("t5_async_addr", instruction_initialize_address, 32'h0);
    checkOutput("t5_async_done", 32'(done), 32'd0);
    checkOutput("t5_async_ready", 32'(in_ready), 32'd0);
    checkOutput("t5_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_idle_ready", 32'(in_ready), 32'd0);
    checkOutput("t5_idle_cpu_rst", 32'(cpu_rst), 32'd1);
    clear_log();
    applyStimulus(16'd1, 32'd0);
    send_word(32'h1234_5678, 1'b0);
    in_valid = 1'b0;
    wait_done("t5_done");
    checkOutput("t5_pulses", 32'(wr_addr_q.size()), 32'd1);
    checkOutput("t5_addr", addr_at(0), 32'h0);
    checkOutput("t5_data", data_at(0), 32'h1234_5678);

    // Test 7: a full-depth program of 64 words, where the last address is 0xFC.
    begin
      logic [31:0] max_addr;
      clear_log();
      applyStimulus(16'd64, 32'd0);
      for (int i = 0; i < 64; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
      in_valid = 1'b0;
      wait_done("t7_done");
      max_addr = 32'h0;
      foreach (wr_addr_q[i]) if (wr_addr_q[i] > max_addr) max_addr = wr_addr_q[i];
      checkOutput("t7_pulses", 32'(wr_addr_q.size()), 32'd64);
      checkOutput("t7_last_addr", addr_at(63), 32'hFC);
      checkOutput("t7_last_data", data_at(63), 32'hA000_003F);
      checkOutput("t7_max_addr", max_addr, 32'hFC);
    end

`ifdef LOADER_CHECKSUM_EN
    // Test 6: the checksum matches, then a second load has a checksum mismatch.
    clear_log();
    applyStimulus(16'd3, 32'd6);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    in_valid = 1'b0;
    wait_done("t6_ok_done");
    checkOutput("t6_ok_error", 32'(error), 32'd0);
    applyStimulus(16'd3, 32'd7);
    send_word(32'd1, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'd3, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_bad_error", 32'(error), 32'd1);
    checkOutput("t6_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("t6_bad_done", 32'(done), 32'd0);
    checkOutput("t6_bad_busy", 32'(busy), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
